// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and FIFO helper types, used by the tx FIFO, transmitter and receiver.
package uart_tx_fifo_pkg;

  localparam int unsigned DataW        = 8;
  localparam int unsigned DefaultDepth = 16;

  // Encoded as {pop, write} so the operation can be built directly from the two strobes.
  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpWrite = 2'b01,
    OpPop   = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing signal bundle of the UART transmit FIFO.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned DEPTH  = DefaultDepth
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [LvlW-1:0]   level;
  logic              overflow;
  logic              underflow;
  logic              err_clr;
  logic              req;
  logic              data_available;
  logic [DATA_W-1:0] data;

  modport master (
    output wr_en, wr_data, err_clr, req,
    input  full, level, overflow, underflow, data_available, data
  );

  modport slave (
    input  wr_en, wr_data, err_clr, req,
    output full, level, overflow, underflow, data_available, data
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one write port and one registered read port, no reset on the array or read data.
module uart_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AddrW-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Same-address write and read in one cycle returns the old entry (pop of a full FIFO).
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: circular buffer with registered count, pop-loaded output byte, sticky errors.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned DATA_W = DataW
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  uart_tx_fifo_if.slave  fifo_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              data_vld_q, data_vld_d;
  logic              active_q;
  logic              full, avail, pop, wr_acc, wr_drop, req_empty;
  logic [DATA_W-1:0] rd_data;
  fifo_op_e          op;

  assign full      = (count_q == CntW'(DEPTH));
  assign avail     = (count_q != '0);
  // active_q masks the strobes on the first edge after reset release.
  assign pop       = active_q & fifo_io.req & avail;
  assign wr_acc    = active_q & fifo_io.wr_en & (~full | pop);
  assign wr_drop   = active_q & fifo_io.wr_en & full & ~pop;
  assign req_empty = active_q & fifo_io.req & ~avail;

  always_comb begin
    op         = fifo_op_e'({pop, wr_acc});
    wr_ptr_d   = wr_acc ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case (op)
      OpWrite: count_d = count_q + CntW'(1);
      OpPop:   count_d = count_q - CntW'(1);
      OpNone,
      OpBoth:  count_d = count_q;
      default: count_d = count_q;
    endcase
    // Setting events win over a same-cycle clear.
    ovf_d      = wr_drop | (ovf_q & ~fifo_io.err_clr);
    unf_d      = req_empty | (unf_q & ~fifo_io.err_clr);
    data_vld_d = data_vld_q | pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      data_vld_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      data_vld_q <= data_vld_d;
      active_q   <= 1'b1;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_io.wr_data),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // The read register has no reset, so the byte is masked to zero until the first pop.
  assign fifo_io.data           = data_vld_q ? rd_data : '0;
  assign fifo_io.full           = full;
  assign fifo_io.level          = count_q;
  assign fifo_io.data_available = avail;
  assign fifo_io.overflow       = ovf_q;
  assign fifo_io.underflow      = unf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table plus fill, wrap and reset sequences.
module tb_uart_tx_fifo;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       req;
    logic       err_clr;
    int         lvl;
    logic       full;
    logic       avail;
    logic [7:0] data;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_tx_fifo #(
    .DEPTH  (16),
    .DATA_W (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .fifo_io (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.req     = r;
    bus.err_clr = c;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int lvl, input logic f, input logic a,
                             input logic [7:0] d, input logic o, input logic u);
    check({tag, ".level"}, int'(bus.level), lvl);
    check({tag, ".full"}, int'(bus.full), int'(f));
    check({tag, ".avail"}, int'(bus.data_available), int'(a));
    check({tag, ".data"}, int'(bus.data), int'(d));
    check({tag, ".ovf"}, int'(bus.overflow), int'(o));
    check({tag, ".unf"}, int'(bus.underflow), int'(u));
  endtask

  vec_t       vecs [14];
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  initial begin
    //          wr  data   req err  lvl full avail data   ovf unf
    vecs[0]  = '{H, 8'h55, L,  L,   1,  L,   H,    8'h00, L,  L};
    vecs[1]  = '{H, 8'hA3, L,  L,   2,  L,   H,    8'h00, L,  L};
    vecs[2]  = '{L, 8'h00, H,  L,   1,  L,   H,    8'h55, L,  L};
    vecs[3]  = '{L, 8'h00, L,  L,   1,  L,   H,    8'h55, L,  L};
    vecs[4]  = '{L, 8'h00, H,  L,   0,  L,   L,    8'hA3, L,  L};
    vecs[5]  = '{H, 8'h3C, L,  L,   1,  L,   H,    8'hA3, L,  L};
    vecs[6]  = '{L, 8'h00, H,  L,   0,  L,   L,    8'h3C, L,  L};
    vecs[7]  = '{L, 8'h00, H,  L,   0,  L,   L,    8'h3C, L,  H};
    vecs[8]  = '{L, 8'h00, L,  L,   0,  L,   L,    8'h3C, L,  H};
    vecs[9]  = '{L, 8'h00, L,  H,   0,  L,   L,    8'h3C, L,  L};
    vecs[10] = '{L, 8'h00, H,  H,   0,  L,   L,    8'h3C, L,  H};
    vecs[11] = '{L, 8'h00, L,  H,   0,  L,   L,    8'h3C, L,  L};
    vecs[12] = '{H, 8'h11, H,  L,   1,  L,   H,    8'h3C, L,  H};
    vecs[13] = '{L, 8'h00, H,  H,   0,  L,   L,    8'h11, L,  L};

    drive(L, 8'h00, L, L);
    step();
    step();
    check_state("reset", 0, L, L, 8'h00, L, L);

    // Release mid-cycle with a write pending: the first edge must ignore it.
    rst_ni = 1'b1;
    drive(H, 8'hEE, L, L);
    step();
    check("release_ignored.level", int'(bus.level), 0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].req, vecs[i].err_clr);
      step();
      check_state($sformatf("v%0d", i), vecs[i].lvl, vecs[i].full, vecs[i].avail,
                  vecs[i].data, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to full, then a dropped write.
    for (int i = 0; i < 16; i++) begin
      drive(H, 8'(i), L, L);
      step();
    end
    check_state("filled", 16, H, H, 8'h11, L, L);
    drive(H, 8'hFF, L, L);
    step();
    check_state("overflow", 16, H, H, 8'h11, H, L);
    drive(L, 8'h00, L, H);
    step();
    check("ovf_clr", int'(bus.overflow), 0);

    // Write and pop together at full: accepted, level unchanged, no overflow.
    drive(H, 8'h77, H, L);
    step();
    check_state("full_wr_pop", 16, H, H, 8'h00, L, L);
    for (int i = 1; i <= 16; i++) begin
      drive(L, 8'h00, H, L);
      step();
      check($sformatf("drain%0d", i), int'(bus.data), (i == 16) ? 32'h77 : i);
    end
    drive(L, 8'h00, L, L);
    check("drained.level", int'(bus.level), 0);

    // 40-byte stream with concurrent pops; pointers wrap more than twice.
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      drive(H, 8'(i * 7 + 3), (i >= 4), L);
      step();
      if (i >= 4 && sb.size() > 0) begin
        exp_b = sb.pop_front();
        check($sformatf("stream%0d", i), int'(bus.data), int'(exp_b));
      end
      sb.push_back(8'(i * 7 + 3));
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      drive(L, 8'h00, H, L);
      step();
      exp_b = sb.pop_front();
      check($sformatf("tail%0d", k), int'(bus.data), int'(exp_b));
    end
    drive(L, 8'h00, L, L);
    step();
    check_state("stream_end", 0, L, L, 8'(39 * 7 + 3), L, L);

    // Asynchronous reset mid-cycle with 5 bytes queued.
    for (int i = 0; i < 5; i++) begin
      drive(H, 8'hA0 + 8'(i), L, L);
      step();
    end
    drive(L, 8'h00, L, L);
    check("pre_reset.level", int'(bus.level), 5);
    #2;
    rst_ni = 1'b0;
    #1;
    check_state("async_rst", 0, L, L, 8'h00, L, L);
    step();
    step();
    rst_ni = 1'b1;
    step();
    drive(H, 8'h42, L, L);
    step();
    check("post_rst_wr.level", int'(bus.level), 1);
    drive(L, 8'h00, H, L);
    step();
    drive(L, 8'h00, L, L);
    check_state("post_rst_pop", 0, L, L, 8'h42, L, L);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter DATA_W, default 8, byte width; SHALL match the UART transmitter data width.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 wr_en  in  1  producer write strobe, one byte per asserted cycle.
REQ-006 wr_data  in  DATA_W  byte to enqueue.
REQ-007 full  out  1  high when count == DEPTH.
REQ-008 level  out  $clog2(DEPTH)+1  current number of stored entries.
REQ-009 overflow  out  1  sticky: a write was dropped.
REQ-010 underflow  out  1  sticky: req arrived while empty.
REQ-011 err_clr  in  1  synchronous clear of overflow and underflow.
REQ-012 req  in  1  one-cycle pop pulse from the transmitter.
REQ-013 data_available  out  1  high when level != 0.
REQ-014 data  out  DATA_W  registered byte presented to the transmitter.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries with write and read pointers of $clog2(DEPTH) bits; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 A write SHALL be accepted when wr_en && (!full || pop), where pop = req && data_available; an accepted write stores wr_data at the write pointer and increments it.
REQ-017 A write with wr_en && full && !pop SHALL be dropped, leave all pointers, level and data unchanged, and set overflow the next cycle.
REQ-018 On pop, data SHALL load the entry at the read pointer on that same clock edge, so data is valid on the cycle after req; the read pointer increments.
REQ-019 data SHALL then hold unchanged until the next pop, because the transmitter samples it up to one baud period after req.
REQ-020 req while level == 0 SHALL leave data, pointers and level unchanged and set underflow.
REQ-021 level SHALL increment on a write-only cycle, decrement on a pop-only cycle, and stay unchanged on a simultaneous accepted write and pop, including at level == 0 with wr_en && req (no pop occurs: level becomes 1, underflow set).
REQ-022 full, data_available and level SHALL be derived from the registered count only; there SHALL be no combinational path from wr_en or req to any output.
REQ-023 err_clr SHALL clear both sticky flags; if a flag-setting event and err_clr occur in the same cycle, the flag SHALL be set.
REQ-024 Latency: a write into an empty FIFO SHALL raise data_available on the next cycle.

Reset
REQ-025 rst low SHALL immediately clear the pointers, level, data, overflow and underflow, and drive full=0 and data_available=0; storage contents are not reset.
REQ-026 Reset asserted mid-transfer SHALL discard all queued bytes; the first write after release SHALL be the next byte presented.
REQ-027 The block SHALL not respond to wr_en or req in the cycle where rst deasserts.

Structure
REQ-028 DATA_W and the default DEPTH SHALL live in the shared UART constants include, also used by tx and rx.
REQ-029 Storage SHALL be a sub-module uart_fifo_mem (one write port, one synchronous read port, no reset); pointer and count control SHALL stay in uart_tx_fifo.

Verification
REQ-030 Reset, then write 0x55, 0xA3, then pulse req twice -> data_available=1 one cycle after the first write; data=0x55, then 0xA3; level back to 0.
REQ-031 Write 16 bytes 0x00..0x0F, then a 17th 0xFF -> full=1, level=16, overflow=1; popping all 16 yields 0x00..0x0F, and 0xFF never appears.
REQ-032 With level=16, wr_en with 0x77 and req in the same cycle -> write accepted, level stays 16, overflow stays 0, and 0x77 is the 16th byte popped.
REQ-033 req at level 0 with data=0x3C -> data stays 0x3C, underflow=1; err_clr -> underflow=0 next cycle.
REQ-034 Enqueue 40 bytes while driving the UART transmitter at 115200 baud -> the serial line carries all 40 in order with no duplicates, exercising pointer wrap.
REQ-035 Write 5 bytes, pull rst low asynchronously mid-clock -> outputs clear before the next edge; after release, writing 0x42 and popping once yields data=0x42.
